// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, DATA_BITS data bits sent LSB first, then a stop period.
// Bit timing advances only on baud oversample ticks.
module uart_tx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bau_tick_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);

  localparam int CNT_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int SW      = $clog2(CNT_MAX);
  localparam int NW      = $clog2(DATA_BITS);

  localparam logic [SW-1:0] OS_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_TICKS - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t               r_state, w_state_next;
  logic [SW-1:0]        r_s_cnt, w_s_cnt_next;
  logic [NW-1:0]        r_n_cnt, w_n_cnt_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 r_done, w_done_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_s_cnt <= w_s_cnt_next;
      r_n_cnt <= w_n_cnt_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_s_cnt_next = r_s_cnt;
    w_n_cnt_next = r_n_cnt;
    w_shift_next = r_shift;
    w_done_next  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_s_cnt_next = '0;
        w_n_cnt_next = '0;
        if (tx_valid_i) begin
          w_shift_next = tx_data_i;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (bau_tick_i) begin
          if (r_s_cnt == OS_LAST) begin
            w_state_next = S_DATA;
            w_s_cnt_next = '0;
            w_n_cnt_next = '0;
          end else begin
            w_s_cnt_next = r_s_cnt + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bau_tick_i) begin
          if (r_s_cnt == OS_LAST) begin
            w_shift_next = r_shift >> 1;
            w_s_cnt_next = '0;
            if (r_n_cnt == N_LAST) begin
              w_state_next = S_STOP;
            end else begin
              w_n_cnt_next = r_n_cnt + 1'b1;
            end
          end else begin
            w_s_cnt_next = r_s_cnt + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bau_tick_i) begin
          if (r_s_cnt == STOP_LAST) begin
            w_state_next = S_IDLE;
            w_s_cnt_next = '0;
            w_done_next  = 1'b1;
          end else begin
            w_s_cnt_next = r_s_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_s_cnt_next = '0;
        w_n_cnt_next = '0;
      end
    endcase
  end

  // The line is registered, so it is derived from the state being entered.
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  assign tx_ready_o = (r_state == S_IDLE);
  assign tx_busy_o  = (r_state != S_IDLE);
  assign tx_o       = r_tx;
  assign tx_done_o  = r_done;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: default 8N1 instance plus a 7-bit / 32-tick-stop instance.
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tick = 1'b0;
  logic tick_en = 1'b1;
  int   tick_div = 0;

  logic [7:0] a_data;
  logic       a_valid, a_ready, a_tx, a_busy, a_done;
  logic [6:0] b_data;
  logic       b_valid, b_ready, b_tx, b_busy, b_done;

  bit   sel = 1'b0;
  logic m_tx, m_busy, m_done, m_ready;
  assign m_tx    = sel ? b_tx    : a_tx;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_ready = sel ? b_ready : a_ready;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_ctrl u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .bau_tick_i (tick),
    .tx_data_i  (a_data),
    .tx_valid_i (a_valid),
    .tx_ready_o (a_ready),
    .tx_o       (a_tx),
    .tx_busy_o  (a_busy),
    .tx_done_o  (a_done)
  );

  uart_tx_ctrl #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_TICKS(32)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .bau_tick_i (tick),
    .tx_data_i  (b_data),
    .tx_valid_i (b_valid),
    .tx_ready_o (b_ready),
    .tx_o       (b_tx),
    .tx_busy_o  (b_busy),
    .tx_done_o  (b_done)
  );

  // One tick every 4 clocks, changed on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      tick_div = (tick_div + 1) % 4;
      tick = tick_en && (tick_div == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    if (sel) begin
      b_data  = d[6:0];
      b_valid = 1'b1;
    end else begin
      a_data  = d;
      a_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; returns 1 time unit after the edge following done.
  task automatic mon_frame(input string tag, input int dbits, input int sticks,
                           input logic [10:0] exp_bits, input int exp_ticks,
                           input bit scramble, input int gate_at);
    int         ticks, dones, rdy_hi, cyc, chg;
    bit         tk;
    logic       frz;
    logic [10:0] got;
    ticks = 0; dones = 0; rdy_hi = 0; cyc = 0; got = '0;
    chk({tag, "_acc_busy"}, m_busy, 1'b1);
    while (m_busy && cyc < 20000) begin
      @(posedge clk);
      tk = tick;
      if (tk) ticks++;
      #1;
      cyc++;
      if (scramble) a_data = 8'($urandom);
      if (m_done) dones++;
      if (m_busy && m_ready) rdy_hi++;
      if (tk) begin
        for (int b = 0; b <= dbits; b++)
          if (ticks == 16 * b + 8) got[b] = m_tx;
        if (ticks == 16 * (dbits + 1) + sticks / 2) got[dbits + 1] = m_tx;
        if (ticks == gate_at) begin
          tick_en = 1'b0;
          frz = m_tx;
          chg = 0;
          repeat (1000) begin
            @(posedge clk);
            #1;
            if (m_tx !== frz || m_busy !== 1'b1) chg++;
          end
          tick_en = 1'b1;
          chk({tag, "_frozen"}, chg, 0);
        end
      end
    end
    chk({tag, "_timeout"}, (cyc < 20000), 1'b1);
    chk({tag, "_bits"}, got, exp_bits);
    chk({tag, "_ticks"}, ticks, exp_ticks);
    chk({tag, "_done_cnt"}, dones, 1);
    chk({tag, "_ready_busy"}, rdy_hi, 0);
    chk({tag, "_end_ready"}, m_ready, 1'b1);
    chk({tag, "_end_tx"}, m_tx, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, "_done_clr"}, m_done, 1'b0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, dn;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", a_tx, 1'b1);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_ready", a_ready, 1'b1);
    chk("rst_tx_b", b_tx, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    repeat (20) @(posedge clk);
    #1;
    chk("idle_tx", a_tx, 1'b1);
    chk("idle_busy", a_busy, 1'b0);

    // Basic frame
    send(8'hA5);
    mon_frame("basic", 8, 16, {1'b0, 1'b1, 8'hA5, 1'b0}, 160, 1'b0, -1);

    // Back-to-back with valid held; data change during frame 1 must not leak in
    @(negedge clk);
    a_data = 8'h00;
    a_valid = 1'b1;
    @(posedge clk);
    #1;
    a_data = 8'hFF;
    mon_frame("b2b_1", 8, 16, {1'b0, 1'b1, 8'h00, 1'b0}, 160, 1'b0, -1);
    a_valid = 1'b0;
    chk("b2b_start_tx", a_tx, 1'b0);
    mon_frame("b2b_2", 8, 16, {1'b0, 1'b1, 8'hFF, 1'b0}, 160, 1'b0, -1);

    // Input stability under per-cycle data churn
    send(8'h5A);
    mon_frame("stable", 8, 16, {1'b0, 1'b1, 8'h5A, 1'b0}, 160, 1'b1, -1);

    // Asynchronous reset during data bit 3
    send(8'h3C);
    t = 0; c = 0;
    while (t < 72 && c < 2000) begin
      @(posedge clk);
      if (tick) t++;
      c++;
    end
    chk("pre_rst_busy", a_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_tx", a_tx, 1'b1);
    chk("abort_busy", a_busy, 1'b0);
    chk("abort_ready", a_ready, 1'b1);
    dn = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (a_done) dn++;
    end
    chk("abort_no_done", dn, 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h3C);
    mon_frame("after_rst", 8, 16, {1'b0, 1'b1, 8'h3C, 1'b0}, 160, 1'b0, -1);

    // Tick gating mid-DATA
    send(8'h96);
    mon_frame("gate", 8, 16, {1'b0, 1'b1, 8'h96, 1'b0}, 160, 1'b0, 40);

    // 7 data bits, 32-tick stop
    sel = 1'b1;
    send(8'h41);
    mon_frame("p7s32", 7, 32, {2'b00, 1'b1, 7'h41, 1'b0}, 160, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, number of data bits per frame (5..9).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, baud ticks per bit period (>=2).
REQ-003 The block SHALL have parameter STOP_TICKS, default 16, baud ticks in the stop period (>=1; 24 = 1.5 stop bits, 32 = 2).
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port bau_tick_i, input, 1, one-clk-wide oversample tick from the baud generator.
REQ-007 The block SHALL have port tx_data_i, input, DATA_BITS, byte to send, sampled on accept.
REQ-008 The block SHALL have port tx_valid_i, input, 1, requester has data.
REQ-009 The block SHALL have port tx_ready_o, output, 1, block can accept; high only in IDLE.
REQ-010 The block SHALL have port tx_o, output, 1, registered serial line, idle high.
REQ-011 The block SHALL have port tx_busy_o, output, 1, high in any state other than IDLE.
REQ-012 The block SHALL have port tx_done_o, output, 1, one-clk pulse at frame end.

Function
REQ-013 The block SHALL implement FSM states IDLE, START, DATA and STOP, with a tick counter s_cnt of width clog2(max(OVERSAMPLE,STOP_TICKS)), a bit counter n_cnt and a DATA_BITS shift register.
REQ-014 The block SHALL accept a request on a clk edge where tx_valid_i && tx_ready_o, latching tx_data_i, clearing s_cnt and entering START.
REQ-015 The block SHALL drive tx_o low from the clk edge that enters START.
REQ-016 In START, the block SHALL increment s_cnt on each bau_tick_i; on the tick with s_cnt==OVERSAMPLE-1 it SHALL enter DATA with s_cnt=0 and n_cnt=0.
REQ-017 The first start period SHALL span the accept edge to the OVERSAMPLE-th tick, with no tick alignment; it is accepted as up to one tick short.
REQ-018 In DATA, tx_o SHALL equal shift-register bit 0, sending LSB first.
REQ-019 In DATA, on the tick with s_cnt==OVERSAMPLE-1 the block SHALL shift right, clear s_cnt, and then enter STOP if n_cnt==DATA_BITS-1, otherwise increment n_cnt.
REQ-020 In STOP, tx_o SHALL be high; on the tick with s_cnt==STOP_TICKS-1 the block SHALL enter IDLE and assert tx_done_o for exactly one clk on that same edge.
REQ-021 The block SHALL ignore bau_tick_i in IDLE and hold s_cnt at 0 there.
REQ-022 The block SHALL ignore tx_valid_i and tx_data_i while busy; a held tx_data_i change mid-frame SHALL NOT alter the frame.
REQ-023 Back-to-back operation: on the cycle tx_done_o is high, the block is IDLE and tx_ready_o=1, so a pending request SHALL be accepted on that edge.
REQ-024 On each back-to-back accept, tx_o SHALL go low on the next edge with no idle-high gap beyond the stop period.
REQ-025 Frame length SHALL be exactly (1+DATA_BITS)*OVERSAMPLE + STOP_TICKS ticks, measured from the first tick after accept, minus at most one tick (REQ-017).
REQ-026 s_cnt and n_cnt SHALL never exceed their terminal values, and all counter comparisons SHALL be unsigned.

Reset
REQ-027 While rst=1, the block SHALL force state IDLE, tx_o=1, tx_busy_o=0, tx_done_o=0, s_cnt=0, n_cnt=0 and shift register=0, with tx_ready_o=1 (IDLE-derived).
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately, asynchronously, and drive tx_o high with no tx_done_o.
REQ-029 After rst deasserts, the block SHALL accept a new request on the first clk edge with tx_valid_i=1.

Verification
REQ-030 Basic frame: defaults with tick every 4 clk, send 8'hA5, then sample tx_o mid-bit -> 0,1,0,1,0,0,1,0,1,1; busy for 160 ticks (+/-1); one done pulse.
REQ-031 Back-to-back: hold tx_valid_i high with 8'h00 then 8'hFF -> second start bit directly follows the first frame's 16-tick stop; tx_ready_o high only on handoff cycles.
REQ-032 Input stability: change tx_data_i every clk while busy -> serialized bits equal the value latched at accept.
REQ-033 Reset mid-DATA: rst pulse at bit 3 of 8'h3C -> tx_o=1 within the same cycle, no done pulse, and the next request sends a full clean frame.
REQ-034 Parameters: DATA_BITS=7, STOP_TICKS=32, send 7'h41 -> 7 data bits, 32-tick stop, frame 160 ticks.
REQ-035 Tick gating: no ticks for 1000 clk while in DATA -> tx_o and the state are frozen and resume correctly when ticks return.
